// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, fetch FSM states and helpers for the LEGv8 fetch stage
//
// Purpose : common definitions imported by the fetch unit and its prefetch queue.
// Ports   : none (package).

package cpu_pkg;

  // Instruction word width.
  localparam int INSTR_W = 32;

  // Opcode field [31:21] that marks HALT.
  localparam logic [10:0] HALT_OPC = 11'h7FF;

  // Fetch FSM state encoding.
  localparam int FSM_W = 2;
  localparam logic [FSM_W-1:0] FS_RUN       = 2'd0;
  localparam logic [FSM_W-1:0] FS_HALT_PEND = 2'd1;
  localparam logic [FSM_W-1:0] FS_HALTED    = 2'd2;
  localparam logic [FSM_W-1:0] FS_FAULT     = 2'd3;

  // True when an instruction's opcode field matches the HALT opcode.
  function automatic logic is_halt(input logic [10:0] opc_field,
                                   input logic [10:0] halt_opc);
    return opc_field == halt_opc;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous prefetch FIFO with flush and occupancy count
//
// Purpose : holds fetched {instruction, pc} entries between memory and decode.
// Ports   :
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data at the tail
//   push_data    DW-bit entry
//   pop          drop the head entry
//   flush        empty the queue (wins over push/pop)
//   head_data    current head entry (valid when !empty)
//   empty        queue holds no entries
//   count        number of entries held (0..DEPTH)

module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DW    = 96,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [DW-1:0]    head_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [DW-1:0]    mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + CNT_W'(1);
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only observed behind the pointers.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end
  end

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign head_data = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - sequential LEGv8 fetch stage with prefetch queue, redirect and HALT
//
// Purpose : owns the PC, issues word requests to a variable-latency instruction memory,
//           buffers responses in a prefetch queue and hands instructions to decode.
// Ports   :
//   clk, rst_n                         clock, asynchronous active-low reset
//   imem_req_valid/ready/addr          request channel to instruction memory
//   imem_rsp_valid/data                in-order response channel
//   instr_valid/ready/data/pc          head of the prefetch queue towards decode
//   redirect_valid/pc                  taken branch: flush and refetch from redirect_pc
//   halted                             HALT consumed by decode; fetch stopped
//   fault                              misaligned or out-of-range PC

module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned        ADDR_W     = 64,
  parameter int unsigned        IMEM_BYTES = 4096,
  parameter int unsigned        QDEPTH     = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter logic [10:0]        HALT_OPC   = cpu_pkg::HALT_OPC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic              fault
);

  localparam int CNT_W   = $clog2(QDEPTH) + 1;
  localparam int ENTRY_W = INSTR_W + ADDR_W;
  localparam logic [ADDR_W-1:0] IMEM_LIMIT = ADDR_W'(IMEM_BYTES);

  logic [ADDR_W-1:0] pc_q, pc_d;
  // PC of the next response that will actually be kept.
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  // Responses still owed for requests made before the last redirect.
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic [FSM_W-1:0]  state_q, state_d;

  logic [CNT_W-1:0]   q_count;
  logic               q_empty;
  logic [ENTRY_W-1:0] q_head;

  logic [CNT_W:0]    inflight;
  logic [ADDR_W-1:0] pc_plus4;
  logic redirect_eff, redirect_bad, can_issue, req_fire;
  logic rsp_keep, q_push, q_pop, push_halt, pop_halt, head_valid;

  always_comb begin
    inflight     = {1'b0, q_count} + {1'b0, outstanding_q};
    pc_plus4     = pc_q + ADDR_W'(4);
    redirect_eff = redirect_valid && (state_q == FS_RUN || state_q == FS_HALT_PEND);
    redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= IMEM_LIMIT);
    // Queue slots are reserved for every in-flight request, so the queue cannot overflow.
    can_issue    = (state_q == FS_RUN) && (inflight < (CNT_W+1)'(QDEPTH)) && !redirect_eff;
    req_fire     = can_issue && imem_req_ready;
    // In FAULT the words already requested are still legal and drain normally;
    // in HALT_PEND/HALTED anything past the HALT is dropped.
    rsp_keep     = imem_rsp_valid && (discard_q == '0) &&
                   (state_q == FS_RUN || state_q == FS_FAULT);
    q_push       = rsp_keep && !redirect_eff;
    push_halt    = q_push && (state_q == FS_RUN) && is_halt(imem_rsp_data[31:21], HALT_OPC);
    head_valid   = !q_empty && (state_q != FS_HALTED);
    q_pop        = head_valid && instr_ready && !redirect_eff;
    pop_halt     = q_pop && (state_q == FS_HALT_PEND) &&
                   is_halt(q_head[ENTRY_W-1:ENTRY_W-11], HALT_OPC);
  end

  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    state_d       = state_q;
    if (redirect_eff) begin
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
      // A response arriving this cycle is counted as dropped.
      if (imem_rsp_valid) begin
        outstanding_d = outstanding_q - CNT_W'(1);
      end
      discard_d = outstanding_d;
      state_d   = redirect_bad ? FS_FAULT : FS_RUN;
    end else begin
      if (req_fire) begin
        pc_d = pc_plus4;
      end
      unique case ({req_fire, imem_rsp_valid})
        2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
        2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
        default: outstanding_d = outstanding_q;
      endcase
      if (imem_rsp_valid && (discard_q != '0)) begin
        discard_d = discard_q - CNT_W'(1);
      end
      if (q_push) begin
        rsp_pc_d = rsp_pc_q + ADDR_W'(4);
      end
      unique case (state_q)
        FS_RUN: begin
          // HALT is older in program order than any request issued this cycle.
          if (push_halt) begin
            state_d = FS_HALT_PEND;
          end else if (req_fire && (pc_plus4 >= IMEM_LIMIT)) begin
            state_d = FS_FAULT;
          end
        end
        FS_HALT_PEND: begin
          if (pop_halt) begin
            state_d = FS_HALTED;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      state_q       <= FS_RUN;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      state_q       <= state_d;
    end
  end

  fetch_queue #(
    .DW    (ENTRY_W),
    .DEPTH (QDEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_data ({imem_rsp_data, rsp_pc_q}),
    .pop       (q_pop),
    .flush     (redirect_eff),
    .head_data (q_head),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Request valid is held low while reset is asserted so every output reads 0.
  assign imem_req_valid = can_issue && rst_n;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = head_valid;
  assign instr_data     = head_valid ? q_head[ENTRY_W-1:ADDR_W] : '0;
  assign instr_pc       = head_valid ? q_head[ADDR_W-1:0] : '0;
  assign halted         = (state_q == FS_HALTED);
  assign fault          = (state_q == FS_FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit

module tb_instr_fetch_unit;

  localparam int ADDR_W     = 64;
  localparam int IMEM_BYTES = 4096;
  localparam int QDEPTH     = 4;
  localparam int NWORDS     = IMEM_BYTES / 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halted;
  logic              fault;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W     (ADDR_W),
    .IMEM_BYTES (IMEM_BYTES),
    .QDEPTH     (QDEPTH),
    .RESET_PC   (64'd0),
    .HALT_OPC   (11'h7FF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fault          (fault)
  );

  // Behavioural instruction memory: in-order responses, per-request latency.
  typedef struct {
    int               t;
    logic [ADDR_W-1:0] a;
  } pend_t;

  logic [31:0] mem [NWORDS];
  pend_t       pend_q [$];

  int checks = 0;
  int errors = 0;
  int cyc, last_t, acc_cnt, acc_limit, ready_pct, lat_min, lat_max;
  logic [ADDR_W-1:0] max_acc_addr;

  logic              cons_v;
  logic [ADDR_W-1:0] cons_pc;
  logic [31:0]       cons_data;
  logic              smp_req_valid, smp_halted, smp_fault, smp_instr_valid;

  // One clock of memory behaviour; called mid-cycle, returns at the next mid-cycle.
  task automatic cycle();
    int lat, t;
    if (pend_q.size() > 0 && pend_q[0].t <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem[pend_q[0].a[11:2]];
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    if (acc_limit >= 0 && acc_cnt >= acc_limit) imem_req_ready = 1'b0;
    else imem_req_ready = ($urandom_range(99) < ready_pct);
    #1;
    cons_v          = instr_valid && instr_ready;
    cons_pc         = instr_pc;
    cons_data       = instr_data;
    smp_req_valid   = imem_req_valid;
    smp_halted      = halted;
    smp_fault       = fault;
    smp_instr_valid = instr_valid;
    if (imem_req_valid && imem_req_ready) begin
      lat = $urandom_range(lat_max, lat_min);
      t = cyc + lat;
      if (t <= last_t) t = last_t + 1;
      last_t = t;
      pend_q.push_back('{t, imem_req_addr});
      acc_cnt++;
      if (imem_req_addr > max_acc_addr) max_acc_addr = imem_req_addr;
    end
    if (imem_rsp_valid) void'(pend_q.pop_front());
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    pend_q.delete();
    cyc = 0; last_t = -1; acc_cnt = 0; acc_limit = -1;
    ready_pct = 100; lat_min = 1; lat_max = 1;
    max_acc_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({imem_req_valid, instr_valid, halted, fault} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000", {imem_req_valid, instr_valid, halted, fault});
    end
    checks++;
    if (imem_req_addr !== 64'd0 || instr_pc !== 64'd0 || instr_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_data addr %h pc %h data %h exp all 0", imem_req_addr, instr_pc, instr_data);
    end
    do_reset();
  endtask

  task automatic test_straight_line();
    logic [ADDR_W-1:0] pcs [$];
    logic [31:0]       dat [$];
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (cons_v) begin pcs.push_back(cons_pc); dat.push_back(cons_data); end
    end
    checks++;
    if (pcs.size() < 8) begin
      errors++;
      $display("FAIL straight_count got %0d exp >=8", pcs.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (pcs[i] !== 64'(4*i) || dat[i] !== mem[i]) begin
          errors++;
          $display("FAIL straight[%0d] pc %h data %h exp pc %h data %h", i, pcs[i], dat[i], 4*i, mem[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    instr_ready = 1'b0;
    for (int k = 0; k < 10; k++) cycle();
    checks++;
    if (acc_cnt !== QDEPTH) begin
      errors++;
      $display("FAIL backpressure_reqs got %0d exp %0d", acc_cnt, QDEPTH);
    end
    checks++;
    if (smp_req_valid !== 1'b0 || smp_instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_stall req_valid %b instr_valid %b exp 0 1", smp_req_valid, smp_instr_valid);
    end
  endtask

  task automatic test_redirect();
    logic [ADDR_W-1:0] pcs [$];
    logic [31:0]       dat [$];
    do_reset();
    acc_limit = 2; lat_min = 6; lat_max = 6;
    for (int k = 0; k < 3; k++) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    cycle();
    checks++;
    if (smp_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_no_issue got %b exp 0", smp_req_valid);
    end
    redirect_valid = 1'b0;
    acc_limit = -1; lat_min = 1; lat_max = 2;
    instr_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (cons_v) begin pcs.push_back(cons_pc); dat.push_back(cons_data); end
    end
    checks++;
    if (pcs.size() < 4) begin
      errors++;
      $display("FAIL redirect_count got %0d exp >=4", pcs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pcs[i] !== 64'(64 + 4*i) || dat[i] !== mem[16+i]) begin
          errors++;
          $display("FAIL redirect[%0d] pc %h data %h exp pc %h data %h", i, pcs[i], dat[i], 64+4*i, mem[16+i]);
        end
      end
    end
  endtask

  task automatic test_halt();
    logic [ADDR_W-1:0] pcs [$];
    int c_cyc = -1;
    int h_cyc = -1;
    logic [31:0] saved;
    saved  = mem[3];
    mem[3] = 32'hFFE0_0000;
    do_reset();
    instr_ready = 1'b1;
    ready_pct = 80; lat_min = 1; lat_max = 3;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (cons_v) begin
        pcs.push_back(cons_pc);
        if (cons_pc == 64'h0C) c_cyc = k;
      end
      if (smp_halted && h_cyc < 0) h_cyc = k;
    end
    checks++;
    if (pcs.size() != 4) begin
      errors++;
      $display("FAIL halt_count got %0d exp 4", pcs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pcs[i] !== 64'(4*i)) begin
          errors++;
          $display("FAIL halt_pc[%0d] got %h exp %h", i, pcs[i], 4*i);
        end
      end
    end
    checks++;
    if (c_cyc < 0 || h_cyc !== c_cyc + 1) begin
      errors++;
      $display("FAIL halt_timing halted at %0d exp %0d", h_cyc, c_cyc + 1);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    cycle();
    redirect_valid = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    checks++;
    if (smp_halted !== 1'b1 || smp_instr_valid !== 1'b0 || smp_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_sticky halted %b instr_valid %b req_valid %b exp 1 0 0",
               smp_halted, smp_instr_valid, smp_req_valid);
    end
    mem[3] = saved;
  endtask

  task automatic test_misaligned_redirect();
    int bad_req = 0;
    do_reset();
    for (int k = 0; k < 2; k++) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h42;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    checks++;
    if (smp_fault !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_fault got %b exp 1", smp_fault);
    end
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (smp_req_valid) bad_req++;
    end
    checks++;
    if (bad_req != 0) begin
      errors++;
      $display("FAIL misaligned_no_req got %0d requests exp 0", bad_req);
    end
  endtask

  task automatic test_end_of_mem();
    logic [ADDR_W-1:0] pcs [$];
    logic [31:0]       dat [$];
    do_reset();
    lat_min = 1; lat_max = 3;
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'(IMEM_BYTES - 16);
    cycle();
    redirect_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (cons_v) begin pcs.push_back(cons_pc); dat.push_back(cons_data); end
    end
    checks++;
    if (smp_fault !== 1'b1 || smp_instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL eom_state fault %b instr_valid %b exp 1 0", smp_fault, smp_instr_valid);
    end
    checks++;
    if (max_acc_addr >= 64'(IMEM_BYTES)) begin
      errors++;
      $display("FAIL eom_max_addr got %h exp < %h", max_acc_addr, IMEM_BYTES);
    end
    checks++;
    if (pcs.size() != 4) begin
      errors++;
      $display("FAIL eom_count got %0d exp 4", pcs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pcs[i] !== 64'(IMEM_BYTES - 16 + 4*i) || dat[i] !== mem[NWORDS-4+i]) begin
          errors++;
          $display("FAIL eom[%0d] pc %h data %h exp pc %h data %h", i, pcs[i], dat[i],
                   IMEM_BYTES - 16 + 4*i, mem[NWORDS-4+i]);
        end
      end
    end
  endtask

  // Random traffic against a program-order model: the expected stream is sequential
  // from the last redirect target.
  task automatic test_random();
    logic [ADDR_W-1:0] exp_pc = '0;
    int n_cons = 0;
    do_reset();
    ready_pct = 70; lat_min = 1; lat_max = 4;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(99) < 4) begin
        redirect_valid = 1'b1;
        redirect_pc    = 64'($urandom_range(511)) << 2;
        instr_ready    = 1'b0;
      end else begin
        redirect_valid = 1'b0;
        instr_ready    = ($urandom_range(99) < 60);
      end
      cycle();
      if (cons_v) begin
        n_cons++;
        checks++;
        if (cons_pc !== exp_pc || cons_data !== mem[exp_pc[11:2]]) begin
          errors++;
          $display("FAIL random_instr pc %h data %h exp pc %h data %h",
                   cons_pc, cons_data, exp_pc, mem[exp_pc[11:2]]);
        end
        exp_pc = exp_pc + 64'd4;
      end
      if (redirect_valid) exp_pc = redirect_pc;
    end
    redirect_valid = 1'b0;
    checks++;
    if (n_cons < 20 || smp_fault !== 1'b0 || smp_halted !== 1'b0) begin
      errors++;
      $display("FAIL random_summary consumed %0d fault %b halted %b exp >=20 0 0",
               n_cons, smp_fault, smp_halted);
    end
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) mem[i] = $urandom & 32'h7FFF_FFFF;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    test_reset();
    test_straight_line();
    test_backpressure();
    test_redirect();
    test_halt();
    test_misaligned_redirect();
    test_end_of_mem();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
